// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns with valid/ready handshakes.
// COLS_PER_CYCLE columns are transformed per clock; the result is held until taken.
module mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] indata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outdata,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int unsigned NCYC     = 4 / COLS_PER_CYCLE;
  localparam int unsigned LAST_COL = (NCYC - 1) * COLS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic [1:0]     r_cnt;
  logic           r_inv;
  logic [127:0]   r_in;
  logic [127:0]   r_out;

  logic [1:0]     w_idx [COLS_PER_CYCLE];
  logic [31:0]    w_res [COLS_PER_CYCLE];
  logic           w_last;
  logic           w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Every coefficient is a sum of 1, 2, 4 and 8 times the byte, so one xtime chain serves both directions.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0]  a  [4];
    logic [7:0]  x2 [4];
    logic [7:0]  x4 [4];
    logic [7:0]  x8 [4];
    logic [1:0]  j0, j1, j2, j3;
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      j0     = 2'(i);
      a[j0]  = col[31-8*i -: 8];
      x2[j0] = xtime(a[j0]);
      x4[j0] = xtime(x2[j0]);
      x8[j0] = xtime(x4[j0]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      j0 = 2'(r);
      j1 = j0 + 2'd1;
      j2 = j0 + 2'd2;
      j3 = j0 + 2'd3;
      if (inv)
        res[31-8*r -: 8] = (x8[j0] ^ x4[j0] ^ x2[j0]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
                           (x8[j2] ^ x4[j2] ^ a[j2])  ^ (x8[j3] ^ a[j3]);
      else
        res[31-8*r -: 8] = x2[j0] ^ (x2[j1] ^ a[j1]) ^ a[j2] ^ a[j3];
    end
    return res;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
      w_idx[k] = r_cnt + 2'(k);
      w_res[k] = mix_col(r_in[{~w_idx[k], 5'b0} +: 32], r_inv);
    end
  end

  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == LAST_COL[1:0]);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign outdata   = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_in    <= '0;
      r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in    <= indata;
            r_inv   <= in_inv;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          for (int unsigned k = 0; k < COLS_PER_CYCLE; k++)
            r_out[{~w_idx[k], 5'b0} +: 32] <= w_res[k];
          r_cnt <= r_cnt + 2'(COLS_PER_CYCLE);
          if (w_last)
            r_state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              r_in    <= indata;
              r_inv   <= in_inv;
              r_cnt   <= '0;
              r_state <= BUSY;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) exercised in turn
// with known-answer vectors, handshake corner cases and a random round trip.
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic         in_inv;
  logic [127:0] indata;
  logic [2:0]   out_valid;
  logic         out_ready;
  logic [127:0] outdata [3];
  logic [2:0]   busy;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_inv    (in_inv),
      .indata    (indata),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .outdata   (outdata[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         inv;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t         tbl [4];
  logic [127:0] sb [$];
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inv) cf = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = din[127 - 32*c - 8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(cf[j], a[(r + j) % 4]);
        res[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_pop(input int d, input string nm);
    logic [127:0] e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: output with empty scoreboard, got %h", nm, outdata[d]);
    end else begin
      e = sb.pop_front();
      chk(nm, outdata[d], e);
    end
  endtask

  task automatic wait_ready(input int d, input string nm);
    int t;
    t = 0;
    while (!in_ready[d] && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[d]) chk({nm, " accept timeout"}, {127'd0, in_ready[d]}, 128'd1);
  endtask

  // One block through the unit; optionally toggles in_inv every cycle while busy.
  task automatic run_block(input int d, input logic inv, input logic [127:0] din,
                           input logic [127:0] exp, input bit toggle, input string nm);
    int lat;
    in_inv      = inv;
    indata      = din;
    out_ready   = 1'b1;
    in_valid[d] = 1'b1;
    wait_ready(d, nm);
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    chk({nm, " busy"}, {127'd0, busy[d]}, 128'd1);
    lat = 0;
    while (!out_valid[d] && lat < 20) begin
      if (toggle) in_inv = ~in_inv;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, 128'(lat), 128'(4 >> d));
    if (out_valid[d]) check_pop(d, {nm, " data"});
    else void'(sb.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic backpressure(input int d);
    logic [127:0] a, e;
    int t;
    a = rnd128();
    e = model(a, 1'b0);
    in_inv      = 1'b0;
    indata      = a;
    out_ready   = 1'b0;
    in_valid[d] = 1'b1;
    wait_ready(d, "bp");
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    t = 0;
    while (!out_valid[d] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    indata      = rnd128();
    in_valid[d] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp hold data", outdata[d], e);
      chk("bp hold valid", {127'd0, out_valid[d]}, 128'd1);
      chk("bp in_ready", {127'd0, in_ready[d]}, 128'd0);
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
    check_pop(d, "bp data");
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released valid", {127'd0, out_valid[d]}, 128'd0);
    chk("bp released busy", {127'd0, busy[d]}, 128'd0);
  endtask

  task automatic back_to_back(input int d);
    localparam int N = 6;
    logic [127:0] blk [N];
    int acc_cyc [N];
    int sent, got, cyc;
    bit acc;
    for (int i = 0; i < N; i++) blk[i] = rnd128();
    sent = 0; got = 0; cyc = 0;
    in_inv      = 1'b0;
    out_ready   = 1'b1;
    indata      = blk[0];
    in_valid[d] = 1'b1;
    while (got < N && cyc < 200) begin
      if (out_valid[d]) begin
        check_pop(d, "b2b data");
        got++;
      end
      acc = in_valid[d] && in_ready[d];
      if (acc) begin
        sb.push_back(model(blk[sent], 1'b0));
        acc_cyc[sent] = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < N) indata = blk[sent];
        else in_valid[d] = 1'b0;
      end
    end
    in_valid[d] = 1'b0;
    chk("b2b received", 128'(got), 128'(N));
    chk("b2b leftover", 128'(sb.size()), 128'd0);
    for (int i = 1; i < sent; i++)
      chk("b2b interval", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'((4 >> d) + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x, f;
    int seen;

    tbl[0] = '{1'b0, 128'hdb135345_f20a225c_2d26314c_c6c6c6c6,
                     128'h8e4da1bc_9fdc589d_4d7ebdf8_c6c6c6c6};
    tbl[1] = '{1'b0, 128'hd4d4d4d5_c6c6c6c6_db135345_2d26314c,
                     128'hd5d5d7d6_c6c6c6c6_8e4da1bc_4d7ebdf8};
    tbl[2] = '{1'b1, 128'h8e4da1bc_9fdc589d_4d7ebdf8_c6c6c6c6,
                     128'hdb135345_f20a225c_2d26314c_c6c6c6c6};
    tbl[3] = '{1'b1, 128'hd5d5d7d6_c6c6c6c6_8e4da1bc_4d7ebdf8,
                     128'hd4d4d4d5_c6c6c6c6_db135345_2d26314c};

    rst = 1'b1; in_valid = '0; in_inv = 1'b0; indata = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("reset out_valid", {127'd0, out_valid[d]}, 128'd0);
      chk("reset outdata", outdata[d], 128'd0);
      chk("reset busy", {127'd0, busy[d]}, 128'd0);
      chk("reset in_ready", {127'd0, in_ready[d]}, 128'd1);
    end

    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++)
        run_block(d, tbl[i].inv, tbl[i].din, tbl[i].exp, 1'b0, "kat");
      x = rnd128();
      run_block(d, 1'b0, x, model(x, 1'b0), 1'b1, "mode fwd");
      run_block(d, 1'b1, x, model(x, 1'b1), 1'b1, "mode inv");
      backpressure(d);
      back_to_back(d);
      for (int i = 0; i < 1000; i++) begin
        x = rnd128();
        f = model(x, 1'b0);
        run_block(d, 1'b0, x, f, 1'b0, "rt fwd");
        run_block(d, 1'b1, f, x, 1'b0, "rt inv");
      end
    end

    // Reset during the second busy cycle of the one-column-per-cycle instance.
    indata = rnd128(); in_inv = 1'b0; in_valid[0] = 1'b1;
    wait_ready(0, "rst");
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst out_valid", {127'd0, out_valid[0]}, 128'd0);
    chk("rst outdata", outdata[0], 128'd0);
    chk("rst busy", {127'd0, busy[0]}, 128'd0);
    chk("rst in_ready", {127'd0, in_ready[0]}, 128'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid[0]) seen++;
      @(posedge clk); #1;
    end
    chk("rst no output", 128'(seen), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
